// File: rtl/jtcps1_vram_srv_if.sv
// rtl/jtcps1_vram_srv_if.sv - DMA, CPU and SDRAM bus signals of the CPS1 VRAM responder
interface jtcps1_vram_srv_if #(
  parameter int AW = 17
);
  logic          br;
  logic          bg;
  logic          vram_cs;
  logic [AW:1]   vram_addr;
  logic [15:0]   vram_data;
  logic          vram_ok;
  logic          vram_clr;
  logic          cpu_cs;
  logic          cpu_rnw;
  logic [AW:1]   cpu_addr;
  logic [15:0]   cpu_din;
  logic [1:0]    cpu_dsn;
  logic [15:0]   cpu_dout;
  logic          cpu_ok;
  logic          mem_req;
  logic          mem_we;
  logic [AW:1]   mem_addr;
  logic [15:0]   mem_din;
  logic [1:0]    mem_dsn;
  logic [15:0]   mem_dout;
  logic          mem_rdy;

  modport slave (
    input  br, vram_cs, vram_addr, vram_clr,
    input  cpu_cs, cpu_rnw, cpu_addr, cpu_din, cpu_dsn,
    input  mem_dout, mem_rdy,
    output bg, vram_data, vram_ok, cpu_dout, cpu_ok,
    output mem_req, mem_we, mem_addr, mem_din, mem_dsn
  );

  modport master (
    output br, vram_cs, vram_addr, vram_clr,
    output cpu_cs, cpu_rnw, cpu_addr, cpu_din, cpu_dsn,
    output mem_dout, mem_rdy,
    input  bg, vram_data, vram_ok, cpu_dout, cpu_ok,
    input  mem_req, mem_we, mem_addr, mem_din, mem_dsn
  );
endinterface

// File: rtl/jtcps1_vram_srv.sv
// rtl/jtcps1_vram_srv.sv - VRAM responder: grants the bus to the video DMA, serves its reads
// through a one-word latch and serves CPU accesses while the DMA does not own the bus.
module jtcps1_vram_srv #(
  parameter int AW      = 17,
  parameter int GNT_DLY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  jtcps1_vram_srv_if.slave    bus
);
  typedef enum logic [2:0] {IDLE, CPU, GWAIT, DMA, DRD} state_t;

  state_t       state, state_nx;
  logic [1:0]   cnt, cnt_nx;
  logic         valid, valid_nx;
  logic [AW:1]  lat_addr, lat_addr_nx;
  logic         bg_r, bg_nx;
  logic         cpu_ok_r, cpu_ok_nx;
  logic         mem_req_r, mem_req_nx;
  logic         mem_we_r, mem_we_nx;
  logic [15:0]  vram_data_r, vram_data_nx;
  logic [15:0]  cpu_dout_r, cpu_dout_nx;
  logic [15:0]  mem_din_r, mem_din_nx;
  logic [AW:1]  mem_addr_r, mem_addr_nx;
  logic [1:0]   mem_dsn_r, mem_dsn_nx;
  logic         hit;

  assign hit           = valid && (lat_addr == bus.vram_addr);
  assign bus.vram_ok   = bg_r & hit & ~bus.vram_clr;
  assign bus.bg        = bg_r;
  assign bus.vram_data = vram_data_r;
  assign bus.cpu_ok    = cpu_ok_r;
  assign bus.cpu_dout  = cpu_dout_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_din   = mem_din_r;
  assign bus.mem_dsn   = mem_dsn_r;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    valid_nx     = bus.vram_clr ? 1'b0 : valid;
    lat_addr_nx  = lat_addr;
    bg_nx        = bg_r;
    cpu_ok_nx    = 1'b0;
    mem_req_nx   = mem_req_r;
    mem_we_nx    = mem_we_r;
    vram_data_nx = vram_data_r;
    cpu_dout_nx  = cpu_dout_r;
    mem_din_nx   = mem_din_r;
    mem_addr_nx  = mem_addr_r;
    mem_dsn_nx   = mem_dsn_r;
    case (state)
      IDLE: begin
        if (bus.br) begin
          state_nx = GWAIT;
          cnt_nx   = 2'd0;
        // cpu_ok still high means cpu_cs belongs to the access just finished
        end else if (bus.cpu_cs && !cpu_ok_r) begin
          state_nx    = CPU;
          mem_req_nx  = 1'b1;
          mem_we_nx   = ~bus.cpu_rnw;
          mem_addr_nx = bus.cpu_addr;
          mem_din_nx  = bus.cpu_din;
          mem_dsn_nx  = bus.cpu_dsn;
        end
      end
      CPU: begin
        if (bus.mem_rdy) begin
          mem_req_nx = 1'b0;
          cpu_ok_nx  = 1'b1;
          if (!mem_we_r) cpu_dout_nx = bus.mem_dout;
          if (mem_we_r && mem_addr_r == lat_addr) valid_nx = 1'b0;
          state_nx = bus.br ? GWAIT : IDLE;
          cnt_nx   = 2'd0;
        end
      end
      GWAIT: begin
        if (!bus.br) begin
          state_nx = IDLE;
        end else if (cnt == 2'(GNT_DLY - 1)) begin
          bg_nx    = 1'b1;
          valid_nx = 1'b0;
          state_nx = DMA;
        end else begin
          cnt_nx = cnt + 2'd1;
        end
      end
      DMA: begin
        if (!bus.br) begin
          bg_nx    = 1'b0;
          state_nx = IDLE;
        end else if (bus.vram_cs && !hit) begin
          state_nx    = DRD;
          mem_req_nx  = 1'b1;
          mem_we_nx   = 1'b0;
          mem_addr_nx = bus.vram_addr;
          mem_dsn_nx  = 2'b00;
        end
      end
      DRD: begin
        bg_nx = bg_r & bus.br;
        // The SDRAM request always runs to completion; data is kept only if the grant survived
        if (bus.mem_rdy) begin
          mem_req_nx = 1'b0;
          if (bg_r && bus.br) begin
            vram_data_nx = bus.mem_dout;
            lat_addr_nx  = mem_addr_r;
            valid_nx     = 1'b1;
            state_nx     = DMA;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      valid       <= 1'b0;
      lat_addr    <= '0;
      bg_r        <= 1'b0;
      cpu_ok_r    <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      vram_data_r <= 16'd0;
      cpu_dout_r  <= 16'd0;
      mem_din_r   <= 16'd0;
      mem_addr_r  <= '0;
      mem_dsn_r   <= 2'b11;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      valid       <= valid_nx;
      lat_addr    <= lat_addr_nx;
      bg_r        <= bg_nx;
      cpu_ok_r    <= cpu_ok_nx;
      mem_req_r   <= mem_req_nx;
      mem_we_r    <= mem_we_nx;
      vram_data_r <= vram_data_nx;
      cpu_dout_r  <= cpu_dout_nx;
      mem_din_r   <= mem_din_nx;
      mem_addr_r  <= mem_addr_nx;
      mem_dsn_r   <= mem_dsn_nx;
    end
  end
endmodule
